// File: rtl/fwd_dest_pipe.sv
// Destination-register pipeline (EX/MEM/WB) with operand-forwarding select and load-use stall.
// Optional macro FWD_WB_STAGE_EN enables forwarding from the WB stage (code 11).
module fwd_dest_pipe (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] dst_in,
  input  logic       wr_en_in,
  input  logic       load_in,
  input  logic [4:0] rs_a,
  input  logic [4:0] rs_b,
  input  logic       flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       stall,
  output logic [4:0] ex_dst,
  output logic [4:0] mem_dst,
  output logic [4:0] wb_dst,
  output logic       wb_wr_en
);

  localparam logic [4:0] XZR = 5'd31;

  // The load flag only influences anything while the entry sits in EX.
  logic [4:0] r_ex_dst, r_mem_dst, r_wb_dst;
  logic       r_ex_wr, r_mem_wr, r_wb_wr;
  logic       r_ex_ld;

  logic       w_ex_ld_live;
  logic       w_stall;
  logic       w_bubble;
  logic       w_ex_hit_a, w_mem_hit_a, w_wb_hit_a;
  logic       w_ex_hit_b, w_mem_hit_b, w_wb_hit_b;

  assign w_ex_ld_live = r_ex_ld && r_ex_wr && (r_ex_dst != XZR);
  assign w_stall      = !flush && w_ex_ld_live && ((r_ex_dst == rs_a) || (r_ex_dst == rs_b));
  assign w_bubble     = flush || w_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_dst  <= XZR;
      r_ex_wr   <= 1'b0;
      r_ex_ld   <= 1'b0;
      r_mem_dst <= XZR;
      r_mem_wr  <= 1'b0;
      r_wb_dst  <= XZR;
      r_wb_wr   <= 1'b0;
    end else begin
      if (w_bubble) begin
        r_ex_dst <= XZR;
        r_ex_wr  <= 1'b0;
        r_ex_ld  <= 1'b0;
      end else begin
        r_ex_dst <= dst_in;
        r_ex_wr  <= wr_en_in;
        r_ex_ld  <= load_in;
      end
      r_mem_dst <= r_ex_dst;
      r_mem_wr  <= r_ex_wr;
      r_wb_dst  <= r_mem_dst;
      r_wb_wr   <= r_mem_wr;
    end
  end

  // A load in EX cannot supply its data yet, so it never yields code 01.
  always_comb begin
    w_ex_hit_a  = r_ex_wr && !r_ex_ld && (r_ex_dst == rs_a) && (rs_a != XZR);
    w_ex_hit_b  = r_ex_wr && !r_ex_ld && (r_ex_dst == rs_b) && (rs_b != XZR);
    w_mem_hit_a = r_mem_wr && (r_mem_dst == rs_a) && (rs_a != XZR);
    w_mem_hit_b = r_mem_wr && (r_mem_dst == rs_b) && (rs_b != XZR);
`ifdef FWD_WB_STAGE_EN
    w_wb_hit_a  = r_wb_wr && (r_wb_dst == rs_a) && (rs_a != XZR);
    w_wb_hit_b  = r_wb_wr && (r_wb_dst == rs_b) && (rs_b != XZR);
`else
    w_wb_hit_a  = 1'b0;
    w_wb_hit_b  = 1'b0;
`endif
  end

  always_comb begin
    fwd_a = 2'b00;
    if (w_ex_hit_a)       fwd_a = 2'b01;
    else if (w_mem_hit_a) fwd_a = 2'b10;
    else if (w_wb_hit_a)  fwd_a = 2'b11;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (w_ex_hit_b)       fwd_b = 2'b01;
    else if (w_mem_hit_b) fwd_b = 2'b10;
    else if (w_wb_hit_b)  fwd_b = 2'b11;
  end

  assign stall    = w_stall;
  assign ex_dst   = r_ex_dst;
  assign mem_dst  = r_mem_dst;
  assign wb_dst   = r_wb_dst;
  assign wb_wr_en = r_wb_wr;

endmodule

// File: tb/tb_fwd_dest_pipe.sv
// Self-checking bench for fwd_dest_pipe: per-cycle compare against a stage-list model,
// plus directed scenarios with literal expectations. Honors FWD_WB_STAGE_EN if defined.
module tb_fwd_dest_pipe;

`ifdef FWD_WB_STAGE_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] dst_in = 5'd31;
  logic       wr_en_in = 1'b0;
  logic       load_in = 1'b0;
  logic [4:0] rs_a = 5'd0;
  logic [4:0] rs_b = 5'd0;
  logic       flush = 1'b0;
  logic [1:0] fwd_a, fwd_b;
  logic       stall;
  logic [4:0] ex_dst, mem_dst, wb_dst;
  logic       wb_wr_en;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  fwd_dest_pipe dut (
    .clk(clk), .reset(reset), .dst_in(dst_in), .wr_en_in(wr_en_in), .load_in(load_in),
    .rs_a(rs_a), .rs_b(rs_b), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
    .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst), .wb_wr_en(wb_wr_en)
  );

  always #5 clk = ~clk;

  // Model: stage list, index 0 = EX, 1 = MEM, 2 = WB.
  int m_dst[3];
  bit m_wr[3];
  bit m_ld[3];

  function automatic bit m_stall(int ra, int rb, bit fl);
    return !fl && m_ld[0] && m_wr[0] && m_dst[0] != 31 && (m_dst[0] == ra || m_dst[0] == rb);
  endfunction

  function automatic int m_fwd(int rs);
    if (rs == 31) return 0;
    for (int s = 0; s < 3; s++) begin
      if (s == 2 && !WB_EN) continue;
      if (m_wr[s] && m_dst[s] == rs) begin
        if (s == 0 && m_ld[0]) continue;
        return s + 1;
      end
    end
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 3; s++) begin
        m_dst[s] = 31; m_wr[s] = 0; m_ld[s] = 0;
      end
    end else begin
      bit bub;
      bub = flush || m_stall(rs_a, rs_b, flush);
      for (int s = 2; s > 0; s--) begin
        m_dst[s] = m_dst[s-1]; m_wr[s] = m_wr[s-1]; m_ld[s] = m_ld[s-1];
      end
      m_dst[0] = bub ? 31 : int'(dst_in);
      m_wr[0]  = bub ? 1'b0 : wr_en_in;
      m_ld[0]  = bub ? 1'b0 : load_in;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ex_dst",  ex_dst,   m_dst[0]);
      chk("cyc_mem_dst", mem_dst,  m_dst[1]);
      chk("cyc_wb_dst",  wb_dst,   m_dst[2]);
      chk("cyc_wb_wr",   wb_wr_en, m_wr[2]);
      chk("cyc_stall",   stall,    m_stall(rs_a, rs_b, flush));
      chk("cyc_fwd_a",   fwd_a,    m_fwd(rs_a));
      chk("cyc_fwd_b",   fwd_b,    m_fwd(rs_b));
    end
  end

  // Advance one edge, then present the next decode instruction; checks follow 1 unit later.
  task automatic drive(input int d, input bit w, input bit l, input int ra, input int rb, input bit fl);
    @(posedge clk);
    #1;
    dst_in = 5'(d); wr_en_in = w; load_in = l; rs_a = 5'(ra); rs_b = 5'(rb); flush = fl;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(31, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int picks[5] = '{1, 2, 3, 4, 31};
    #1 reset = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_ex_dst", ex_dst, 31);
    chk("rst_wb_wr", wb_wr_en, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk); @(negedge clk);
    #1 reset = 1'b0;
    idle(1);
    chk("post_rst_fwd_a", fwd_a, 0);
    chk("post_rst_mem_dst", mem_dst, 31);

    // ALU result travels EX -> MEM -> WB
    drive(3, 1, 0, 0, 0, 0);
    drive(31, 0, 0, 3, 0, 0);
    chk("alu_fwd_a_ex", fwd_a, 1);
    drive(31, 0, 0, 0, 3, 0);
    chk("alu_fwd_b_mem", fwd_b, 2);
    drive(31, 0, 0, 3, 0, 0);
    chk("alu_fwd_a_wb", fwd_a, WB_EN ? 3 : 0);
    chk("alu_wb_dst", wb_dst, 3);
    chk("alu_wb_wr", wb_wr_en, 1);
    idle(3);

    // Load-use: one stall, then MEM forward
    drive(7, 1, 1, 0, 0, 0);
    drive(31, 0, 0, 0, 7, 0);
    chk("lu_stall", stall, 1);
    chk("lu_fwd_b_fall", fwd_b, 0);
    drive(31, 0, 0, 0, 7, 0);
    chk("lu_ex_bubble", ex_dst, 31);
    chk("lu_fwd_b_mem", fwd_b, 2);
    chk("lu_stall_clr", stall, 0);
    idle(3);

    // Flush overrides load-use stall
    drive(7, 1, 1, 0, 0, 0);
    drive(31, 0, 0, 7, 0, 1);
    chk("fl_stall", stall, 0);
    chk("fl_fwd_a", fwd_a, 0);
    drive(31, 0, 0, 0, 0, 0);
    chk("fl_ex_bubble", ex_dst, 31);
    chk("fl_mem_dst", mem_dst, 7);
    idle(3);

    // Back-to-back load-use stalls
    drive(7, 1, 1, 0, 0, 0);
    drive(8, 1, 1, 7, 0, 0);
    chk("b2b_stall1", stall, 1);
    drive(8, 1, 1, 7, 0, 0);
    chk("b2b_nostall", stall, 0);
    drive(31, 0, 0, 8, 0, 0);
    chk("b2b_stall2", stall, 1);
    idle(3);

    // EX beats MEM; XZR never forwards or stalls
    drive(4, 1, 0, 0, 0, 0);
    drive(4, 1, 0, 0, 0, 0);
    drive(31, 0, 0, 4, 0, 0);
    chk("prio_fwd_a", fwd_a, 1);
    drive(31, 1, 1, 0, 0, 0);
    drive(31, 0, 0, 31, 31, 0);
    chk("xzr_fwd_a", fwd_a, 0);
    chk("xzr_stall", stall, 0);
    idle(3);

    // Non-writing instruction still tracked but never forwarded
    drive(9, 0, 0, 0, 0, 0);
    drive(31, 0, 0, 9, 0, 0);
    chk("nw_fwd_a", fwd_a, 0);
    chk("nw_ex_dst", ex_dst, 9);
    idle(2);
    chk("nw_wb_dst", wb_dst, 9);
    chk("nw_wb_wr", wb_wr_en, 0);

    // Mid-stream reset with dst=5 writers in every stage
    drive(5, 1, 0, 0, 0, 0);
    drive(5, 1, 0, 0, 0, 0);
    drive(5, 1, 0, 0, 0, 0);
    drive(31, 0, 0, 5, 5, 0);
    chk("pre_rst_wb_wr", wb_wr_en, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_ex", ex_dst, 31);
    chk("mid_rst_mem", mem_dst, 31);
    chk("mid_rst_wb", wb_dst, 31);
    chk("mid_rst_wb_wr", wb_wr_en, 0);
    chk("mid_rst_fwd_a", fwd_a, 0);
    chk("mid_rst_fwd_b", fwd_b, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    idle(1);

    // Mixed traffic, checked by the per-cycle compare
    for (int i = 0; i < 200; i++) begin
      drive(picks[$urandom_range(4)], 1'($urandom_range(1)), 1'($urandom_range(1)),
            picks[$urandom_range(4)], picks[$urandom_range(4)], $urandom_range(7) == 0);
    end
    idle(2);
    @(posedge clk);
    #1 chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
